pipe_sim: RTL and testbench

// - Four-stage in-order pipeline model (S0 capture, S1 decode, S2 execute, S3 retire) carrying 32-bit data beats.
// - Each beat is tagged as ALU or load. A load holds S2 for LOAD_LAT cycles and back-pressures upstream.
// - Standalone sandbox for validating valid/stall/bubble handling before it is reused in the core pipeline.

---
 rtl/pipe_sim_pkg.sv | 16 +
 rtl/pipe_sim_if.sv | 13 +
 rtl/pipe_sim_stage.sv | 13 +
 rtl/pipe_sim.sv | 48 ++++
 tb/tb_pipe_sim.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_sim_pkg.sv
// pipe_sim_pkg: shared stage record, defaults and execute function for pipe_sim.
package pipe_sim_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int LOAD_LAT_DEF = 2;
  typedef struct packed {
    logic valid;
    logic is_load;
    logic [DATA_W_DEF-1:0] data;
  } stage_t;
  function automatic stage_t exec_result(stage_t s);
    stage_t r;
    r = s;
    r.data = s.valid && !s.is_load ? s.data + 1'b1 : s.data;
    return r;
  endfunction
endpackage

// File: rtl/pipe_sim_if.sv
// pipe_sim_if: beat input and retire output bundle of pipe_sim.
interface pipe_sim_if import pipe_sim_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
  logic valid_in;
  logic [DATA_W-1:0] data_in;
  logic is_load;
  logic ready_out;
  logic valid_out;
  logic [DATA_W-1:0] data_out;
  logic load_out;
  logic stall;
  modport master (output valid_in, data_in, is_load, input ready_out, valid_out, data_out, load_out, stall);
  modport slave (input valid_in, data_in, is_load, output ready_out, valid_out, data_out, load_out, stall);
endinterface

// File: rtl/pipe_sim_stage.sv
// pipe_sim_stage: one pipeline register slice with hold and bubble insertion.
module pipe_sim_stage import pipe_sim_pkg::*; (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (!hold) q <= bubble ? '0 : d;
endmodule

// File: rtl/pipe_sim.sv
// pipe_sim: four-stage in-order pipeline with load hold in S2.
// Optional PIPE_SIM_PERF_CNT_EN adds retire_cnt/stall_cnt counters.
module pipe_sim import pipe_sim_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  pipe_sim_if.slave bus
`ifdef PIPE_SIM_PERF_CNT_EN
  ,
  output logic [31:0] retire_cnt,
  output logic [31:0] stall_cnt
`endif
);
  logic [3:0] cnt;
  logic stall;
  logic [DATA_W-1:0] in_data;
  stage_t s0_d, s0_q, s1_q, s2_q, s3_d, s3_q;
  assign stall = cnt != 4'd0;
  assign in_data = bus.data_in;
  assign s0_d = '{valid: 1'b1, is_load: bus.is_load, data: in_data};
  assign s3_d = exec_result(s2_q);
  pipe_sim_stage u_s0 (.clk(clk), .rst_n(rst_n), .hold(stall), .bubble(!bus.valid_in), .d(s0_d), .q(s0_q));
  pipe_sim_stage u_s1 (.clk(clk), .rst_n(rst_n), .hold(stall), .bubble(1'b0), .d(s0_q), .q(s1_q));
  pipe_sim_stage u_s2 (.clk(clk), .rst_n(rst_n), .hold(stall), .bubble(1'b0), .d(s1_q), .q(s2_q));
  pipe_sim_stage u_s3 (.clk(clk), .rst_n(rst_n), .hold(1'b0), .bubble(stall), .d(s3_d), .q(s3_q));
  // A load moving from S1 into S2 arms the hold; the front freezes until it drains.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (stall) cnt <= cnt - 4'd1;
    else if (s1_q.valid && s1_q.is_load) cnt <= 4'(LOAD_LAT - 1);
  assign bus.ready_out = !stall;
  assign bus.stall = stall;
  assign bus.valid_out = s3_q.valid;
  assign bus.data_out = s3_q.data;
  assign bus.load_out = s3_q.is_load;
`ifdef PIPE_SIM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      retire_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      retire_cnt <= retire_cnt + 32'(s3_q.valid);
      stall_cnt <= stall_cnt + 32'(stall);
    end
`endif
endmodule

// File: tb/tb_pipe_sim.sv
// tb_pipe_sim: directed and random checks of pipe_sim (LOAD_LAT 2 and 4) against a delay-line-with-freeze model.
module tb_pipe_sim;
  import pipe_sim_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pipe_sim_if if2 ();
  pipe_sim_if if4 ();
  logic vin[2], lin[2];
  logic [31:0] din[2];
  logic ov[2], ol[2], ost[2], ordy[2];
  logic [31:0] od[2];
  assign if2.valid_in = vin[0];
  assign if2.is_load = lin[0];
  assign if2.data_in = din[0];
  assign if4.valid_in = vin[1];
  assign if4.is_load = lin[1];
  assign if4.data_in = din[1];
  assign ov[0] = if2.valid_out;
  assign ol[0] = if2.load_out;
  assign od[0] = if2.data_out;
  assign ost[0] = if2.stall;
  assign ordy[0] = if2.ready_out;
  assign ov[1] = if4.valid_out;
  assign ol[1] = if4.load_out;
  assign od[1] = if4.data_out;
  assign ost[1] = if4.stall;
  assign ordy[1] = if4.ready_out;
`ifdef PIPE_SIM_PERF_CNT_EN
  logic [31:0] rc[2], sc[2], m_rc[2], m_sc[2];
  pipe_sim #(.LOAD_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2), .retire_cnt(rc[0]), .stall_cnt(sc[0]));
  pipe_sim #(.LOAD_LAT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4), .retire_cnt(rc[1]), .stall_cnt(sc[1]));
`else
  pipe_sim #(.LOAD_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  pipe_sim #(.LOAD_LAT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
`endif
  int lat[2] = '{2, 4};
  // Model: the k-th accepted-or-bubble slot retires at the (k+3)-th advancing edge; a load in S2 inserts LAT-1 frozen edges.
  stage_t hist[2][4096];
  int adv[2], frz[2];
  stage_t exp_o[2];
  bit acc[2];
  int checks = 0, failures = 0;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_out(string tag, int d, logic v, logic [31:0] x);
    chk({tag, "_valid"}, 32'(ov[d]), 32'(v));
    if (v) chk({tag, "_data"}, od[d], x);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      adv[d] = 3;
      frz[d] = 0;
      exp_o[d] = '0;
      acc[d] = 1'b0;
      for (int i = 0; i < 4096; i++) hist[d][i] = '0;
`ifdef PIPE_SIM_PERF_CNT_EN
      m_rc[d] = 0;
      m_sc[d] = 0;
`endif
    end
  endtask

  task automatic offer(int d, logic v, logic l, logic [31:0] x);
    vin[d] = v;
    lin[d] = l;
    din[d] = x;
  endtask

  task automatic idle();
    offer(0, 1'b0, 1'b0, 32'd0);
    offer(1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic step();
    stage_t b;
    for (int d = 0; d < 2; d++) begin
`ifdef PIPE_SIM_PERF_CNT_EN
      m_rc[d] += 32'(exp_o[d].valid);
      m_sc[d] += 32'(frz[d] != 0);
`endif
      acc[d] = vin[d] && frz[d] == 0;
      if (frz[d] != 0) begin
        frz[d]--;
        exp_o[d] = '0;
      end else begin
        adv[d]++;
        hist[d][adv[d] % 4096] = acc[d] ? '{1'b1, lin[d], din[d]} : '0;
        b = hist[d][(adv[d] - 3) % 4096];
        exp_o[d] = b;
        if (b.valid && !b.is_load) exp_o[d].data = b.data + 32'd1;
        b = hist[d][(adv[d] - 2) % 4096];
        if (b.valid && b.is_load) frz[d] = lat[d] - 1;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("valid_out[%0d]", d), 32'(ov[d]), 32'(exp_o[d].valid));
      if (exp_o[d].valid) begin
        chk($sformatf("data_out[%0d]", d), od[d], exp_o[d].data);
        chk($sformatf("load_out[%0d]", d), 32'(ol[d]), 32'(exp_o[d].is_load));
      end
      chk($sformatf("stall[%0d]", d), 32'(ost[d]), 32'(frz[d] != 0));
      chk($sformatf("ready_out[%0d]", d), 32'(ordy[d]), 32'(frz[d] == 0));
`ifdef PIPE_SIM_PERF_CNT_EN
      chk($sformatf("retire_cnt[%0d]", d), rc[d], m_rc[d]);
      chk($sformatf("stall_cnt[%0d]", d), sc[d], m_sc[d]);
`endif
    end
  endtask

  task automatic chk_reset_state(string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_valid"}, 32'(ov[d]), 32'd0);
      chk({tag, "_data"}, od[d], 32'd0);
      chk({tag, "_load"}, 32'(ol[d]), 32'd0);
      chk({tag, "_ready"}, 32'(ordy[d]), 32'd1);
      chk({tag, "_stall"}, 32'(ost[d]), 32'd0);
      chk({tag, "_known"}, 32'($isunknown({ov[d], od[d], ol[d], ordy[d], ost[d]})), 32'd0);
`ifdef PIPE_SIM_PERF_CNT_EN
      chk({tag, "_rc"}, rc[d], 32'd0);
      chk({tag, "_sc"}, sc[d], 32'd0);
`endif
    end
  endtask

  initial begin
    logic [31:0] ret[$];
    int nst, nld;
    bit hit;
    for (int d = 0; d < 2; d++) offer(d, 1'bx, 1'bx, 'x);
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step();
    offer(0, 1'b1, 1'b0, 32'd5); step();
    offer(0, 1'b1, 1'b0, 32'd6); step();
    offer(0, 1'b0, 1'b1, $urandom); step();
    offer(0, 1'b1, 1'b0, 32'd7); step(); chk_out("alu_a", 0, 1'b1, 32'd6);
    offer(0, 1'b1, 1'b0, 32'd8); step(); chk_out("alu_b", 0, 1'b1, 32'd7);
    idle(); step(); chk_out("alu_bubble", 0, 1'b0, 32'd0);
    step(); chk_out("alu_c", 0, 1'b1, 32'd8);
    step(); chk_out("alu_d", 0, 1'b1, 32'd9);
    offer(0, 1'b1, 1'b1, 32'h10); step();
    offer(0, 1'b1, 1'b0, 32'h20); step();
    idle(); step();
    chk("hold_stall", 32'(ost[0]), 32'd1);
    chk("hold_s1", u2.s1_q.data, 32'h20);
    step(); chk("hold_release", 32'(ost[0]), 32'd0); chk_out("hold_gap", 0, 1'b0, 32'd0);
    step(); chk_out("hold_load", 0, 1'b1, 32'h10); chk("hold_load_flag", 32'(ol[0]), 32'd1);
    step(); chk_out("hold_alu", 0, 1'b1, 32'h21);
    offer(1, 1'b1, 1'b1, 32'd1); step();
    offer(1, 1'b1, 1'b1, 32'd2); step();
    idle();
    nst = 0;
    nld = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      nst += int'(ost[1]);
      if (ov[1]) begin
        ret.push_back(od[1]);
        nld += int'(ol[1]);
      end
    end
    chk("lat4_stalls", 32'(nst), 32'd6);
    chk("lat4_retired", 32'(ret.size()), 32'd2);
    chk("lat4_loads", 32'(nld), 32'd2);
    chk("lat4_first", ret.size() > 0 ? ret[0] : 32'hDEAD, 32'd1);
    chk("lat4_second", ret.size() > 1 ? ret[1] : 32'hDEAD, 32'd2);
    offer(0, 1'b1, 1'b0, 32'hFFFF_FFFF); step();
    idle(); step(); step(); step();
    chk_out("wrap", 0, 1'b1, 32'd0);
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++)
        if (!(vin[d] && !acc[d])) offer(d, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom);
      step();
    end
    idle();
    for (int k = 0; k < 20; k++) step();
    offer(0, 1'b1, 1'b1, 32'h55); step();
    idle();
    hit = 1'b0;
    for (int k = 0; k < 8 && !hit; k++) begin
      step();
      hit = ost[0];
    end
    chk("reach_stall", 32'(hit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    offer(0, 1'b1, 1'b0, 32'd3); step();
    idle(); step(); step();
    chk_out("post_rst_empty", 0, 1'b0, 32'd0);
    step();
    chk_out("post_rst", 0, 1'b1, 32'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
